// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier (Q(W-FRAC).FRAC) with selectable rounding,
// saturation to the format range, and a saturating count of clipped results.
module fixed_mult_pipe #(
  parameter int W      = 17,
  parameter int FRAC   = 8,
  parameter int STAGES = 2,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                round_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        ab,
  output logic                clip_int,
  output logic                clip_frac,
  input  logic                sat_clr,
  output logic [CW-1:0]       sat_count
);

  localparam int PW = 2 * W;

  // Bounds of the result format, sign-extended to the width of the rounded product.
  localparam logic signed [PW:0] MAX_R = {{(PW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW:0] MIN_R = {{(PW-W+2){1'b1}}, {(W-1){1'b0}}};

  typedef struct packed {
    logic         clip_int;
    logic         clip_frac;
    logic [W-1:0] ab;
  } res_t;

  function automatic res_t round_sat(input logic signed [PW-1:0] p, input logic rm);
    logic signed [PW:0] half;
    logic signed [PW:0] pr;
    logic signed [PW:0] r;
    res_t               res;
    half          = '0;
    half[FRAC-1]  = rm;
    pr            = {p[PW-1], p} + half;
    r             = pr >>> FRAC;
    res.clip_frac = |p[FRAC-1:0];
    if (r > MAX_R) begin
      res.clip_int = 1'b1;
      res.ab       = {1'b0, {(W-1){1'b1}}};
    end else if (r < MIN_R) begin
      res.clip_int = 1'b1;
      res.ab       = {1'b1, {(W-1){1'b0}}};
    end else begin
      res.clip_int = 1'b0;
      res.ab       = r[W-1:0];
    end
    return res;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole
  // pipeline advances together whenever the output slot is empty or being drained.
  logic adv;
  logic out_valid_q;
  res_t out_res_q;
  logic [CW-1:0] sat_count_q, sat_count_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  logic signed [PW-1:0] prod;
  assign prod = a * b;

  logic fin_valid;
  res_t fin_res;

  generate
    if (STAGES == 1) begin : g_single
      assign fin_valid = in_valid;
      assign fin_res   = round_sat(prod, round_mode);
    end else begin : g_pipe
      logic [STAGES-2:0]    pv_q;
      logic [STAGES-2:0]    prm_q;
      logic signed [PW-1:0] pp_q [STAGES-1];

      // Earlier stages carry the raw product; rounding/saturation feeds the output stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q  <= '0;
          prm_q <= '0;
          for (int i = 0; i < STAGES - 1; i++) pp_q[i] <= '0;
        end else if (adv) begin
          pv_q[0] <= in_valid;
          if (in_valid) begin
            pp_q[0]  <= prod;
            prm_q[0] <= round_mode;
          end
          for (int i = 1; i < STAGES - 1; i++) begin
            pv_q[i] <= pv_q[i-1];
            if (pv_q[i-1]) begin
              pp_q[i]  <= pp_q[i-1];
              prm_q[i] <= prm_q[i-1];
            end
          end
        end
      end

      assign fin_valid = pv_q[STAGES-2];
      assign fin_res   = round_sat(pp_q[STAGES-2], prm_q[STAGES-2]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
    end else if (adv) begin
      out_valid_q <= fin_valid;
      if (fin_valid) out_res_q <= fin_res;
    end
  end

  // Clear takes priority over a simultaneous clipped handshake; the count never wraps.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && out_res_q.clip_int && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign out_valid = out_valid_q;
  assign ab        = out_res_q.ab;
  assign clip_int  = out_res_q.clip_int;
  assign clip_frac = out_res_q.clip_frac;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: directed cases, stalls, random streams, counter
// saturation and mid-flight reset, scored against an arithmetic reference model.
module tb_fixed_mult_pipe;

  localparam int W      = 17;
  localparam int FRAC   = 8;
  localparam int STAGES = 2;
  localparam int CW     = 4;
  localparam int EW     = W + 2;
  localparam int SAT_MAX = (1 << CW) - 1;
  localparam int GO = 0, STALL = 1, RAND = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          round_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  ab;
  logic          clip_int;
  logic          clip_frac;
  logic          sat_clr = 1'b0;
  logic [CW-1:0] sat_count;

  int checks = 0;
  int errors = 0;
  int n_in = 0;
  int n_out = 0;
  int ready_mode = GO;
  int sat_model = 0;
  logic          stall_prev = 1'b0;
  logic [W-1:0]  prev_ab = '0;
  logic [EW-1:0] exp_q[$];

  fixed_mult_pipe #(.W(W), .FRAC(FRAC), .STAGES(STAGES), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
    .out_ready(out_ready), .ab(ab), .clip_int(clip_int), .clip_frac(clip_frac),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  // Clock and consumer-ready generation.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      GO:      out_ready = 1'b1;
      STALL:   out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, optional half-LSB bias, floor division, clamp.
  function automatic logic [EW-1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                          input logic trm);
    longint sa, sb, p, q, r, d, maxv, minv;
    logic ci, cf;
    logic [W-1:0] res;
    sa   = longint'($signed(ta));
    sb   = longint'($signed(tb_v));
    d    = longint'(1) << FRAC;
    p    = sa * sb;
    q    = trm ? p + d / 2 : p;
    r    = q / d;
    if ((q % d) != 0 && q < 0) r = r - 1;
    cf   = ((p % d) != 0);
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    ci   = 1'b0;
    if (r > maxv) begin
      ci = 1'b1; res = maxv[W-1:0];
    end else if (r < minv) begin
      ci = 1'b1; res = minv[W-1:0];
    end else begin
      res = r[W-1:0];
    end
    return {ci, cf, res};
  endfunction

  // Scoreboard / monitor, sampling on the falling edge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      sat_model  = 0;
      stall_prev = 1'b0;
    end else begin
      chk("sat_count", 32'(sat_count), 32'(sat_model));
      chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_ab", 32'(ab), 32'(prev_ab));
      end
      e = '0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ab", 32'(ab), 32'(e[W-1:0]));
          chk("clip_int", 32'(clip_int), 32'(e[W+1]));
          chk("clip_frac", 32'(clip_frac), 32'(e[W]));
          n_out++;
        end
      end
      if (sat_clr) sat_model = 0;
      else if (out_valid && out_ready && e[W+1] && sat_model < SAT_MAX) sat_model++;
      stall_prev = out_valid && !out_ready;
      prev_ab    = ab;
    end
  end

  // Driver tasks: each starts and ends just after a rising edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic trm);
    int g;
    a = ta; b = tb_v; round_mode = trm; in_valid = 1'b1;
    g = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(ta, tb_v, trm));
        n_in++;
        break;
      end
      g++;
      if (g > 200) begin
        chk("send_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic trm,
                        input logic [W-1:0] e_ab, input logic e_ci, input logic e_cf,
                        input string tag);
    int lat;
    ready_mode = GO;
    send(ta, tb_v, trm);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'(STAGES));
    chk({tag, "_ab"}, 32'(ab), 32'(e_ab));
    chk({tag, "_ci"}, 32'(clip_int), 32'(e_ci));
    chk({tag, "_cf"}, 32'(clip_frac), 32'(e_cf));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g;
    ready_mode = GO;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    int sv;
    if ($urandom_range(0, 1) == 0) sv = int'($urandom_range(0, (1 << W) - 1));
    else                           sv = int'($urandom_range(0, 2047)) - 1024;
    return sv[W-1:0];
  endfunction

  initial begin
    int base;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ab", 32'(ab), 32'd0);
    chk("rst_clip_int", 32'(clip_int), 32'd0);
    chk("rst_clip_frac", 32'(clip_frac), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    single(17'h00200, 17'h00200, 1'b0, 17'h00400, 1'b0, 1'b0, "two_sq");
    single(17'h01000, 17'h01000, 1'b0, 17'h0FFFF, 1'b1, 1'b0, "ovf_pos");
    chk("sat_after_ovf", 32'(sat_count), 32'd1);
    single(17'h1F000, 17'h01000, 1'b0, 17'h10000, 1'b0, 1'b0, "min_exact");
    single(17'd384, 17'd1, 1'b0, 17'h00001, 1'b0, 1'b1, "p15_trunc");
    single(17'd384, 17'd1, 1'b1, 17'h00002, 1'b0, 1'b1, "p15_round");
    single(17'h1FE80, 17'd1, 1'b0, 17'h1FFFE, 1'b0, 1'b1, "n15_trunc");
    single(17'h1FE80, 17'd1, 1'b1, 17'h1FFFF, 1'b0, 1'b1, "n15_round");
    single(17'h10000, 17'h1FF00, 1'b0, 17'h0FFFF, 1'b1, 1'b0, "ovf_minxneg1");

    // Eight back-to-back products with a three-cycle consumer stall mid-stream.
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (3) @(posedge clk);
        ready_mode = STALL;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        ready_mode = GO;
      end
    join
    drain();
    chk("stream8_count", 32'(n_out - base), 32'd8);

    // Random stream under random back-pressure.
    ready_mode = RAND;
    for (int i = 0; i < 60; i++) begin
      send(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    chk("in_out_count", 32'(n_out), 32'(n_in));

    // Counter saturation, then clear colliding with a clipped handshake.
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("sat_cleared", 32'(sat_count), 32'd0);
    for (int i = 0; i < SAT_MAX + 1; i++) send(17'h08000, 17'h08000, 1'($urandom_range(0, 1)));
    drain();
    chk("sat_hold_max", 32'(sat_count), 32'(SAT_MAX));
    ready_mode = STALL;
    send(17'h01000, 17'h1E000, 1'b0);
    for (int g = 0; g < 20 && !out_valid; g++) @(negedge clk);
    chk("clr_wait_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    sat_clr = 1'b1;
    ready_mode = GO;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_wins", 32'(sat_count), 32'd0);

    // Reset with two results in flight.
    single(17'h01000, 17'h01000, 1'b0, 17'h0FFFF, 1'b1, 1'b0, "pre_rst");
    ready_mode = STALL;
    send(17'h01000, 17'h01000, 1'b0);
    send(17'h00300, 17'h00100, 1'b1);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ab", 32'(ab), 32'd0);
    chk("mid_rst_clip", 32'(clip_int), 32'd0);
    chk("mid_rst_sat", 32'(sat_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = GO;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    chk("post_rst_sat", 32'(sat_count), 32'd0);
    single(17'h00180, 17'h00200, 1'b0, 17'h00300, 1'b0, 1'b0, "post_rst_op");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
